// File: rtl/pair_avg_pkg.sv
// Shared phase type, width helpers and averaging arithmetic for pair_avg_stream.
// Build option: define PAIR_AVG_ROUND_EN to round half up; otherwise results truncate.
package pair_avg_pkg;

    localparam int FRAME_LEN_DEF = 128;
    localparam int STRIDE_DEF    = 8;
    localparam int CALC_W        = 32;

    typedef enum logic {
        PH_FILL = 1'b0,
        PH_EMIT = 1'b1
    } phase_t;

    function automatic int k_width(input int frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

    function automatic int p_width(input int stride);
        return (stride > 1) ? $clog2(stride) : 1;
    endfunction

    // Widths for the default configuration; instances derive their own via the helpers.
    localparam int K_W = k_width(FRAME_LEN_DEF);
    localparam int P_W = p_width(STRIDE_DEF);

    // One extra bit on the sum keeps a + b exact for any operand width up to CALC_W.
    function automatic logic [CALC_W-1:0] avg_calc(input logic [CALC_W-1:0] a,
                                                   input logic [CALC_W-1:0] b);
        logic [CALC_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
`ifdef PAIR_AVG_ROUND_EN
        return CALC_W'((sum >> 1) + {{CALC_W{1'b0}}, sum[0]});
`else
        return CALC_W'(sum >> 1);
`endif
    endfunction

endpackage

// File: rtl/pair_avg_hist_buf.sv
// Circular history of the last STRIDE samples. rd_data is the entry about to be
// overwritten, i.e. the sample exactly STRIDE accepts older than wr_data.
module pair_avg_hist_buf
    import pair_avg_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int STRIDE = STRIDE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam int PW = p_width(STRIDE);

    logic [PW-1:0]     wp;
    logic [DATA_W-1:0] mem [STRIDE];

    assign rd_data = mem[wp];

    // Explicit wrap so STRIDE need not be a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
        end else if (wr_en) begin
            wp <= (wp == PW'(STRIDE - 1)) ? '0 : wp + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= wr_data;
        end
    end

endmodule

// File: rtl/pair_avg_stream.sv
// Streaming pairwise averager: sample k >= STRIDE of each frame emits avg(x[k-STRIDE], x[k]).
// Build option: PAIR_AVG_ROUND_EN selects round-half-up instead of truncation.
module pair_avg_stream
    import pair_avg_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int STRIDE    = STRIDE_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int KW = k_width(FRAME_LEN);

    logic [KW-1:0]     k;
    logic              accept;
    logic              last_sample;
    phase_t            phase;
    logic [DATA_W-1:0] oldest;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high on
    // that side. in_ready only frees up when the held result leaves this cycle, so an
    // accepted sample can never overwrite an unconsumed result.
    assign in_ready    = !reset && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign last_sample = (k == KW'(FRAME_LEN - 1));
    assign phase       = (k >= KW'(STRIDE)) ? PH_EMIT : PH_FILL;

    pair_avg_hist_buf #(
        .DATA_W (DATA_W),
        .STRIDE (STRIDE)
    ) u_hist (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_data (in_data),
        .rd_data (oldest)
    );

    // The index restarts each frame, so the history slot read in the emit phase was always
    // written within the same frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            k <= '0;
        end else if (accept) begin
            k <= last_sample ? '0 : k + KW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (accept && phase == PH_EMIT) begin
            out_valid <= 1'b1;
            out_data  <= DATA_W'(avg_calc(CALC_W'(oldest), CALC_W'(in_data)));
            out_last  <= last_sample;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pair_avg_stream.sv
// Bench for pair_avg_stream: default, stride-1 and short-frame instances checked against
// a frame-level reference model that feeds one expected queue per instance.
`timescale 1ns/1ps
module tb_pair_avg_stream;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       in_valid = '0;
    logic [2:0]       out_ready = '0;
    logic [2:0][11:0] in_data = '0;
    wire  [2:0]       in_ready;
    wire  [2:0]       out_valid;
    wire  [2:0]       out_last;
    wire  [2:0][11:0] out_data;
    wire  [7:0]       a_out_data;
    wire  [7:0]       r_out_data;

    int          n_tests = 0;
    int          n_fail = 0;
    int          res_cnt [3];
    int          last_cnt [3];
    int          k_m [3];
    int          hist_m [3][128];
    logic [12:0] exp_q0 [$];
    logic [12:0] exp_q1 [$];
    logic [12:0] exp_q2 [$];
    int          r_seen [$];
    logic [12:0] mon_got;
    logic [12:0] mon_exp;
    logic [11:0] hold_d;
    logic        hold_l;
    logic        done;
    int          r0;
    int          r1;
    int          exp_r [3];

    always #5 clk = ~clk;

    assign out_data[0] = {4'b0, a_out_data};
    assign out_data[1] = {4'b0, r_out_data};

    pair_avg_stream u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0][7:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(a_out_data), .out_last(out_last[0])
    );

    pair_avg_stream #(.DATA_W(8), .STRIDE(1), .FRAME_LEN(2)) u_dut_r (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1][7:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(r_out_data), .out_last(out_last[1])
    );

    pair_avg_stream #(.DATA_W(12), .STRIDE(3), .FRAME_LEN(5)) u_dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .out_last(out_last[2])
    );

    function automatic int p_stride(input int id);
        case (id)
            0:       return 8;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int p_flen(input int id);
        case (id)
            0:       return 128;
            1:       return 2;
            default: return 5;
        endcase
    endfunction

    function automatic int q_size(input int id);
        case (id)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [12:0] q_pop(input int id);
        case (id)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
    endtask

    task automatic model_reset();
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        for (int i = 0; i < 3; i++) k_m[i] = 0;
    endtask

    // Reference: keep the current frame's samples; from index STRIDE on, average with the
    // sample STRIDE positions earlier in the same frame.
    task automatic model_accept(input int id, input int d, output logic emitted);
        int          s;
        int          sum;
        int          avg;
        logic [12:0] e;
        s = p_stride(id);
        emitted = 1'b0;
        if (k_m[id] >= s) begin
            sum = hist_m[id][k_m[id] - s] + d;
`ifdef PAIR_AVG_ROUND_EN
            avg = (sum + 1) / 2;
`else
            avg = sum / 2;
`endif
            e = {(k_m[id] == p_flen(id) - 1), 12'(avg)};
            case (id)
                0:       exp_q0.push_back(e);
                1:       exp_q1.push_back(e);
                default: exp_q2.push_back(e);
            endcase
            emitted = 1'b1;
        end
        hist_m[id][k_m[id]] = d;
        k_m[id] = (k_m[id] == p_flen(id) - 1) ? 0 : k_m[id] + 1;
    endtask

    task automatic send(input int id, input int d);
        int   t;
        logic emitted;
        t = 0;
        in_valid[id] = 1'b1;
        in_data[id]  = 12'(d);
        #1;
        while (!in_ready[id]) begin
            @(negedge clk);
            #1;
            t++;
            if (t > 2000) begin
                fail_now("send_timeout");
                in_valid[id] = 1'b0;
                return;
            end
        end
        model_accept(id, d, emitted);
        @(negedge clk);
        in_valid[id] = 1'b0;
        #1;
        if (emitted) check("latency_one_cycle", out_valid[id], 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q_size(0) + q_size(1) + q_size(2)) != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) fail_now("drain_timeout");
        @(negedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        #1;
        if (!reset) begin
            for (int id = 0; id < 3; id++) begin
                if (out_valid[id] && out_ready[id]) begin
                    mon_got = {out_last[id], out_data[id]};
                    if (q_size(id) == 0) begin
                        fail_now($sformatf("unexpected_output_%0d", id));
                    end else begin
                        mon_exp = q_pop(id);
                        check($sformatf("result_inst%0d", id), 32'(mon_got), 32'(mon_exp));
                    end
                    res_cnt[id]++;
                    if (out_last[id]) last_cnt[id]++;
                    if (id == 1) r_seen.push_back(int'(out_data[1]));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        for (int id = 0; id < 3; id++) check("in_ready_in_reset", in_ready[id], 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int id = 0; id < 3; id++) begin
            check("reset_out_valid", out_valid[id], 0);
            check("reset_out_data", out_data[id], 0);
            check("reset_out_last", out_last[id], 0);
            check("in_ready_after_reset", in_ready[id], 1);
        end

        // Ramp frame: results k-4 for k = 8..127, last flag only on the final one.
        out_ready = 3'b111;
        for (int i = 0; i < 128; i++) begin
            send(0, i);
            if (i == 7) check("fill_no_output", out_valid[0], 0);
        end
        drain();
        check("ramp_results", res_cnt[0], 120);
        check("ramp_last_count", last_cnt[0], 1);

        // Rounding pairs through the stride-1, two-sample-frame instance.
        send(1, 3);
        send(1, 4);
        send(1, 255);
        send(1, 0);
        send(1, 255);
        send(1, 255);
        drain();
`ifdef PAIR_AVG_ROUND_EN
        exp_r = '{4, 128, 255};
`else
        exp_r = '{3, 127, 255};
`endif
        check("round_count", r_seen.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("round_pair", (r_seen.size() > i) ? r_seen[i] : -1, exp_r[i]);
        end

        // Backpressure mid-stream, then full-rate recovery.
        r0 = res_cnt[0];
        fork
            begin
                for (int i = 0; i < 40; i++) send(0, $urandom_range(0, 255));
            end
            begin
                int t;
                t = 0;
                while (res_cnt[0] < r0 + 5 && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                out_ready[0] = 1'b0;
                #1;
                check("stall_valid", out_valid[0], 1);
                hold_d = out_data[0];
                hold_l = out_last[0];
                repeat (5) begin
                    @(negedge clk);
                    #1;
                    check("stall_data_stable", out_data[0], hold_d);
                    check("stall_last_stable", out_last[0], hold_l);
                    check("stall_in_ready", in_ready[0], 0);
                end
                @(negedge clk);
                out_ready[0] = 1'b1;
                r1 = res_cnt[0];
                repeat (6) @(negedge clk);
                #2;
                check("resume_throughput", res_cnt[0] - r1, 7);
            end
        join
        drain();

        // Realign to a frame boundary, then two constant frames.
        for (int i = 0; i < 128 && k_m[0] != 0; i++) send(0, $urandom_range(0, 255));
        r0 = res_cnt[0];
        for (int i = 0; i < 128; i++) send(0, 10);
        for (int i = 0; i < 128; i++) send(0, 200);
        drain();
        check("two_frames_results", res_cnt[0] - r0, 240);

        // Reset mid-frame with a held result.
        for (int i = 0; i < 50; i++) begin
            if (i == 49) begin
                @(negedge clk);
                @(negedge clk);
                out_ready[0] = 1'b0;
            end
            send(0, $urandom_range(0, 255));
        end
        check("pre_reset_valid", out_valid[0], 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("reset_clears_valid", out_valid[0], 0);
        model_reset();
        reset = 1'b0;
        out_ready[0] = 1'b1;
        r0 = res_cnt[0];
        for (int i = 0; i < 8; i++) send(0, 30 + i);
        repeat (2) @(negedge clk);
        #1;
        check("post_reset_fill_valid", out_valid[0], 0);
        check("post_reset_fill_count", res_cnt[0], r0);
        send(0, 100);
        drain();
        check("post_reset_first_result", res_cnt[0], r0 + 1);

        // Short frames with random gaps on both sides.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send(2, $urandom_range(0, 4095));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready[2] = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready[2] = 1'b1;
        drain();
        check("small_results", res_cnt[2], 12);
        check("small_last_count", last_cnt[2], 6);
        check("queues_empty", q_size(0) + q_size(1) + q_size(2), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pair_avg_stream.md
Name: pair_avg_stream

Overview:
Streaming pairwise averager. Each frame holds FRAME_LEN samples. Every sample x[k] with k >= STRIDE emits avg(x[k-STRIDE], x[k]), giving FRAME_LEN-STRIDE results per frame. Sits between a sample source and a downstream consumer, with valid/ready handshakes on both sides. Width, stride and frame length are parametrised, and the block works continuously across frames with backpressure.

Parameters:
DATA_W, 8, sample and result width in bits (>= 2)
STRIDE, 8, distance between paired samples (1 <= STRIDE < FRAME_LEN)
FRAME_LEN, 128, samples per frame (>= 2)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
in_data  in  DATA_W  input sample, unsigned
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  DATA_W  averaged result, unsigned
out_last  out  1  marks the final result of a frame (k = FRAME_LEN-1)

Behaviour:
- Reset is synchronous, active-high, on clk. Reset values: out_valid=0, out_data=0, out_last=0, sample index k=0, history write pointer=0. History buffer contents are not reset; they never reach outputs before being rewritten.
- Accept: an input transfer occurs when in_valid && in_ready. in_ready = !out_valid || out_ready, held combinationally low during reset.
- History: a circular buffer of STRIDE entries of DATA_W bits, with write pointer wp wrapping mod STRIDE (STRIDE need not be a power of two). On each accept, buf[wp] <= in_data and wp advances.
- Fill phase (k < STRIDE): the sample is stored only. No output is produced and the output register is unchanged.
- Emit phase (k >= STRIDE): sum = buf[wp] + in_data, computed at DATA_W+1 bits, so there is no overflow. out_data <= avg(sum); out_valid <= 1; out_last <= (k == FRAME_LEN-1).
- Latency: exactly 1 cycle from the accept edge to out_valid high.
- Output hold: while out_valid && !out_ready, out_data and out_last stay stable and in_ready=0.
- Output drain: out_valid clears on an out_ready handshake unless a new emit-phase sample is accepted in the same cycle.
- Simultaneous events: an out_ready handshake and an emit-phase accept in the same cycle load the new result, so out_valid stays 1 and throughput is 1 result per cycle. An out_ready handshake with a fill-phase accept clears out_valid.
- Frame wrap: after k = FRAME_LEN-1, k returns to 0 and a new fill phase starts. Results never pair samples from different frames.
- Reset mid-frame: the partial frame and any pending result are discarded. The first sample after reset is k=0.

Optional Feature:
Macro PAIR_AVG_ROUND_EN.
- Defined: round half up, out = (sum >> 1) + sum[0].
- Undefined: truncate, out = sum >> 1.
- Timing and handshakes are identical in both builds.

Decomposition:
- Package pair_avg_pkg holds:
  - function avg_calc(a, b) with the rounding selection under the macro;
  - localparams K_W = $clog2(FRAME_LEN) and P_W = max(1, $clog2(STRIDE)).
- Sub-module pair_avg_hist_buf: the STRIDE-deep circular register buffer, with write enable, wrap pointer and read-before-write of the oldest entry.
- Top-level block keeps the index counter, phase decode, output register and handshake.

Test Plan:
1. Ramp x[k]=k for 128 samples, out_ready=1, defaults -> 120 results with values 4..123 in order, out_last only on 123, no output during the first 8 accepts.
2. Rounding pairs (3,4), (255,0), (255,255), STRIDE=1 -> with PAIR_AVG_ROUND_EN: 4, 128, 255; without: 3, 127, 255.
3. out_ready low for 5 cycles mid-stream -> out_data and out_last stable, in_ready=0, no lost or duplicated result, throughput resumes at 1 per cycle.
4. Two back-to-back frames with distinct constants (frame A all 10, frame B all 200) -> 120 results of 10 then 120 of 200, never 105.
5. Reset asserted at k=50 with out_valid=1 -> out_valid=0 after the edge; the next frame's first result appears only after 8 new accepts.
6. DATA_W=12, STRIDE=3, FRAME_LEN=5 with random in_valid/out_ready gaps -> 2 results per frame matching the scoreboard, out_last on every second result.
